// File: rtl/ttt_pkg.sv
// Shared opcodes, router FSM states and the event record passed through the event FIFO.
package ttt_pkg;

  localparam logic [3:0] OP_GOOD      = 4'b0000;
  localparam logic [3:0] OP_BAD       = 4'b0001;
  localparam logic [3:0] OP_TALLY     = 4'b1000;
  localparam logic [3:0] OP_COUNTDOWN = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } ttt_state_t;

  // A tally event is either a start (positive increments) or a stop (negative).
  typedef struct packed {
    logic is_start;
  } ttt_event_t;

  // Negative connection weights carry bad tokens.
  function automatic logic [3:0] polarity_op(input logic negative);
    return negative ? OP_BAD : OP_GOOD;
  endfunction

endpackage

// File: rtl/ttt_event_fifo.sv
// Small synchronous show-ahead FIFO for tally events; a pop in the same cycle
// as a push to a full FIFO frees the slot, so the push is still accepted.
module ttt_event_fifo
  import ttt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  ttt_event_t push_data,
  input  logic       pop,
  output ttt_event_t pop_data,
  output logic       full,
  output logic       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ttt_event_t       mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (PW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ttt_token_router.sv
// Fans each tally event out to every downstream processor with a non-zero
// connection weight, one registered beat per target over a valid/ready port.
module ttt_token_router
  import ttt_pkg::*;
#(
  parameter  int NUM_TARGETS = 4,
  parameter  int WEIGHT_BITS = 8,
  parameter  int FIFO_DEPTH  = 4,
  localparam int IDX_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   token_valid,
  input  logic                   token_start,
  input  logic                   token_stop,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_addr,
  input  logic [WEIGHT_BITS-1:0] cfg_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_target,
  output logic [3:0]             out_instruction,
  output logic [WEIGHT_BITS-1:0] out_data,
  output logic                   overflow
);

  localparam logic signed [WEIGHT_BITS-1:0] W_MIN = {1'b1, {(WEIGHT_BITS-1){1'b0}}};
  localparam logic signed [WEIGHT_BITS-1:0] W_MAX = {1'b0, {(WEIGHT_BITS-1){1'b1}}};

  ttt_state_t                    state_reg;
  logic [IDX_W-1:0]              idx_reg;
  logic                          ev_start_reg;
  logic signed [WEIGHT_BITS-1:0] weight_reg [NUM_TARGETS];

  logic                          out_valid_reg;
  logic [IDX_W-1:0]              out_target_reg;
  logic [3:0]                    out_instruction_reg;
  logic [WEIGHT_BITS-1:0]        out_data_reg;
  logic                          overflow_reg;

  logic                          push_event;
  logic                          pop_event;
  ttt_event_t                    push_ev;
  ttt_event_t                    fifo_head;
  logic                          fifo_full;
  logic                          fifo_empty;

  logic [IDX_W-1:0]              next_idx;
  logic                          present_start;
  logic signed [WEIGHT_BITS-1:0] present_w;
  logic                          present_valid;
  logic [3:0]                    present_instr;
  logic [WEIGHT_BITS-1:0]        present_data;
  logic                          hold;
  logic                          last_idx;

  // Start adds |w| (clipped to the positive range), stop subtracts |w|.
  function automatic logic signed [WEIGHT_BITS-1:0] route_value(
    input logic signed [WEIGHT_BITS-1:0] w,
    input logic                          is_start
  );
    if (!is_start) begin
      return (w < 0) ? w : -w;
    end else if (w == W_MIN) begin
      return W_MAX;
    end else begin
      return (w < 0) ? -w : w;
    end
  endfunction

  assign push_event       = enable && token_valid && (token_start ^ token_stop);
  assign pop_event        = enable && (state_reg == ST_LOAD) && !fifo_empty;
  assign push_ev.is_start = token_start;

  ttt_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_event),
    .push_data (push_ev),
    .pop       (pop_event),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  generate
    for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_weight
      always_ff @(posedge clock) begin
        if (reset) begin
          weight_reg[gi] <= '0;
        end else if (cfg_we && (cfg_addr == IDX_W'(gi))) begin
          weight_reg[gi] <= cfg_data;
        end
      end
    end
  endgenerate

  // The next target's weight is sampled only when it is latched into the
  // output registers, so later table writes never disturb a held beat.
  always_comb begin
    next_idx      = (state_reg == ST_LOAD) ? '0 : idx_reg + IDX_W'(1);
    present_start = (state_reg == ST_LOAD) ? fifo_head.is_start : ev_start_reg;
    present_w     = weight_reg[next_idx];
    present_valid = (present_w != '0);
    present_instr = polarity_op(present_w < 0);
    present_data  = route_value(present_w, present_start);
  end

  assign hold     = out_valid_reg && !out_ready;
  assign last_idx = (idx_reg == IDX_W'(NUM_TARGETS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg           <= ST_IDLE;
      idx_reg             <= '0;
      ev_start_reg        <= 1'b0;
      out_valid_reg       <= 1'b0;
      out_target_reg      <= '0;
      out_instruction_reg <= OP_GOOD;
      out_data_reg        <= '0;
    end else if (enable) begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_reg <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          ev_start_reg        <= fifo_head.is_start;
          idx_reg             <= next_idx;
          out_valid_reg       <= present_valid;
          out_target_reg      <= next_idx;
          out_instruction_reg <= present_instr;
          out_data_reg        <= present_data;
          state_reg           <= ST_EMIT;
        end
        ST_EMIT: begin
          if (!hold) begin
            if (last_idx) begin
              out_valid_reg <= 1'b0;
              state_reg     <= fifo_empty ? ST_IDLE : ST_LOAD;
            end else begin
              idx_reg             <= next_idx;
              out_valid_reg       <= present_valid;
              out_target_reg      <= next_idx;
              out_instruction_reg <= present_instr;
              out_data_reg        <= present_data;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (push_event && fifo_full && !pop_event) begin
      overflow_reg <= 1'b1;
    end
  end

  assign out_valid       = out_valid_reg;
  assign out_target      = out_target_reg;
  assign out_instruction = out_instruction_reg;
  assign out_data        = out_data_reg;
  assign overflow        = overflow_reg;

endmodule

// File: tb/tb_ttt_token_router.sv
// Scoreboard bench: stimulus queues the expected beats of every event, a
// negedge monitor pops and compares each accepted beat and checks holds.
module tb_ttt_token_router;
  import ttt_pkg::*;

  localparam int NT    = 4;
  localparam int WB    = 8;
  localparam int DEPTH = 4;
  localparam int IW    = 2;
  localparam int WMAX  = (1 << (WB - 1)) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          token_valid = 1'b0;
  logic          token_start = 1'b0;
  logic          token_stop = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_addr = '0;
  logic [WB-1:0] cfg_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [IW-1:0] out_target;
  logic [3:0]    out_instruction;
  logic [WB-1:0] out_data;
  logic          overflow;

  ttt_token_router #(
    .NUM_TARGETS (NT),
    .WEIGHT_BITS (WB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .token_valid     (token_valid),
    .token_start     (token_start),
    .token_stop      (token_stop),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_data        (cfg_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_target      (out_target),
    .out_instruction (out_instruction),
    .out_data        (out_data),
    .overflow        (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int tgt;
    int instr;
    int data;
  } beat_t;

  beat_t exp_q[$];
  int    beats_left[$];
  int    wmodel[NT];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    issue_cyc = 0;
  bit    mon_en = 1'b0;
  bit    held = 1'b0;
  int    h_t, h_i, h_d;
  beat_t mon_b;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_write(input int idx, input int val);
    cfg_we   = 1'b1;
    cfg_addr = IW'(idx);
    cfg_data = WB'(val);
    tick();
    cfg_we      = 1'b0;
    wmodel[idx] = val;
  endtask

  task automatic set_table(input int w0, input int w1, input int w2, input int w3);
    cfg_write(0, w0);
    cfg_write(1, w1);
    cfg_write(2, w2);
    cfg_write(3, w3);
  endtask

  // Reference: every non-zero weight yields one beat; start gives +|w| clipped
  // to the positive range, stop gives -|w|; negative weights mean bad tokens.
  task automatic model_event(input bit start);
    int n;
    n = 0;
    for (int i = 0; i < NT; i++) begin
      if (wmodel[i] != 0) begin
        beat_t b;
        int    mag;
        mag     = (wmodel[i] < 0) ? -wmodel[i] : wmodel[i];
        b.tgt   = i;
        b.instr = (wmodel[i] < 0) ? 1 : 0;
        b.data  = start ? ((mag > WMAX) ? WMAX : mag) : -mag;
        exp_q.push_back(b);
        n++;
      end
    end
    if (n > 0) beats_left.push_back(n);
  endtask

  task automatic send(input bit s, input bit p, input bit dropped);
    token_valid = 1'b1;
    token_start = s;
    token_stop  = p;
    tick();
    issue_cyc   = cyc;
    token_valid = 1'b0;
    token_start = 1'b0;
    token_stop  = 1'b0;
    if (enable && (s != p) && !dropped) model_event(s);
  endtask

  task automatic first_latency(input string name);
    int lat;
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (out_valid === 1'b1) begin
        lat = cyc - issue_cyc;
        break;
      end
    end
    check(name, lat, 2);
  endtask

  task automatic wait_valid(input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check(name, seen, 1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (2 * NT + 4) tick();
  endtask

  always @(negedge clock) begin
    if (!mon_en) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checks++;
        if (!(out_valid === 1'b1 && int'(out_target) == h_t &&
              int'(out_instruction) == h_i && int'($signed(out_data)) == h_d)) begin
          errors++;
          $display("FAIL hold: got v=%0d t=%0d i=%0d d=%0d expected v=1 t=%0d i=%0d d=%0d",
                   out_valid, out_target, out_instruction, $signed(out_data), h_t, h_i, h_d);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got t=%0d d=%0d expected no beat",
                   out_target, $signed(out_data));
        end else begin
          mon_b = exp_q.pop_front();
          $display("beat t=%0d instr=%0d data=%0d", out_target, out_instruction, $signed(out_data));
          check("beat_target", int'(out_target), mon_b.tgt);
          check("beat_instr", int'(out_instruction), mon_b.instr);
          check("beat_data", int'($signed(out_data)), mon_b.data);
          if (beats_left.size() > 0) begin
            beats_left[0] = beats_left[0] - 1;
            if (beats_left[0] == 0) void'(beats_left.pop_front());
          end
        end
      end
      held = (out_valid === 1'b1) && !out_ready;
      h_t  = int'(out_target);
      h_i  = int'(out_instruction);
      h_d  = int'($signed(out_data));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NT; i++) wmodel[i] = 0;
    repeat (3) tick();
    reset  = 1'b0;
    enable = 1'b1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_target", int'(out_target), 0);
    check("rst_instr", int'(out_instruction), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_overflow", int'(overflow), 0);
    mon_en = 1'b1;

    // Start and stop routing with latency check.
    set_table(3, 0, -5, 127);
    out_ready = 1'b1;
    send(1'b1, 1'b0, 1'b0);
    first_latency("start_latency");
    drain("drain_start");
    send(1'b0, 1'b1, 1'b0);
    first_latency("stop_latency");
    drain("drain_stop");

    // Backpressure on the first beat, with a weight write to the held target.
    out_ready = 1'b0;
    send(1'b1, 1'b0, 1'b0);
    wait_valid("bp_valid");
    cfg_write(0, 9);
    repeat (4) tick();
    drain("drain_bp");
    cfg_write(0, 3);

    // Net-zero strobe and all-zero table produce nothing.
    out_ready = 1'b1;
    send(1'b1, 1'b1, 1'b0);
    set_table(0, 0, 0, 0);
    send(1'b1, 1'b0, 1'b0);
    repeat (15) tick();
    set_table(3, 0, -5, 127);
    send(1'b0, 1'b1, 1'b0);
    first_latency("latency_after_zero");
    drain("drain_zero");

    // Events are ignored while disabled.
    enable = 1'b0;
    send(1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    enable = 1'b1;
    repeat (10) tick();

    // Overflow: sixth back-to-back event is dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(1'b1, 1'b0, i == 5);
    repeat (3) tick();
    check("overflow_set", int'(overflow), 1);
    drain("drain_overflow");
    check("overflow_sticky", int'(overflow), 1);

    // Reset in the middle of an emission.
    out_ready = 1'b0;
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    wait_valid("pre_reset_valid");
    mon_en = 1'b0;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    beats_left.delete();
    for (int i = 0; i < NT; i++) wmodel[i] = 0;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_overflow", int'(overflow), 0);
    check("midrst_target", int'(out_target), 0);
    check("midrst_data", int'(out_data), 0);
    tick();
    mon_en    = 1'b1;
    out_ready = 1'b1;
    repeat (10) tick();
    send(1'b1, 1'b0, 1'b0);
    repeat (15) tick();

    // Randomized rounds; round 0 uses the saturation boundary weights.
    for (int r = 0; r < 4; r++) begin
      if (r == 0) begin
        set_table(-128, 0, 127, -1);
      end else begin
        int w[NT];
        int nz;
        nz = 0;
        for (int i = 0; i < NT; i++) begin
          w[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($signed(WB'($urandom_range(0, 255))));
          if (w[i] != 0) nz++;
        end
        if (nz == 0) w[$urandom_range(0, NT - 1)] = -128;
        set_table(w[0], w[1], w[2], w[3]);
      end
      for (int c = 0; c < 150; c++) begin
        out_ready = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 2) == 0 && beats_left.size() < DEPTH) begin
          send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end else begin
          tick();
        end
      end
      drain("drain_random");
    end
    check("final_overflow", int'(overflow), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
